// File: rtl/cache_controller.sv
// cache_controller: 2-way set-associative, write-through, no-write-allocate
// data cache between the EXE/MEM pipeline register and the SRAM controller.
// Read hits complete combinationally in the request cycle. Read misses fetch
// the two-word line with two SRAM reads. Every store is written through to
// SRAM. ready drops while an SRAM access is outstanding.
//
// Ports:
//   clk, rst                  pipeline clock, synchronous active-high reset
//   address, wdata            byte address and store data from the pipeline
//   MEM_R_EN, MEM_W_EN        load / store request levels, held until ready
//   rdata, ready              load data and pipeline-advance (0 = stall)
//   sram_address, sram_wdata  word-aligned SRAM address and store data
//   sram_read_en/write_en     SRAM request levels, held until sram_ready
//   sram_rdata, sram_ready    SRAM read data and completion strobe
module cache_controller #(
  parameter int unsigned SETS_LOG2 = 6,
  parameter int unsigned ADDR_W    = 19
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] address,
  input  logic [31:0] wdata,
  input  logic        MEM_R_EN,
  input  logic        MEM_W_EN,
  output logic [31:0] rdata,
  output logic        ready,
  output logic [31:0] sram_address,
  output logic [31:0] sram_wdata,
  output logic        sram_write_en,
  output logic        sram_read_en,
  input  logic [31:0] sram_rdata,
  input  logic        sram_ready
);

  localparam int unsigned SETS  = 1 << SETS_LOG2;
  localparam int unsigned TAG_W = ADDR_W - 3 - SETS_LOG2;

  typedef enum logic [1:0] {IDLE, FETCH0, FETCH1, WRITE} state_t;

  state_t state, state_next;

  logic [SETS-1:0]  valid [2];
  logic [SETS-1:0]  lru;                 // per set: way to replace next
  logic [TAG_W-1:0] tags  [2][SETS];
  logic [31:0]      words [2][SETS][2];
  logic [31:0]      fill_word0;

  logic                 word_sel;
  logic [SETS_LOG2-1:0] index;
  logic [TAG_W-1:0]     tag;
  logic                 hit0, hit1, hit, hit_way, victim;
  logic [31:0]          hit_word;
  logic                 unused_addr_bits;

  assign word_sel = address[2];
  assign index    = address[2+SETS_LOG2:3];
  assign tag      = address[ADDR_W-1:3+SETS_LOG2];
  assign unused_addr_bits = ^address[1:0];

  assign hit0     = valid[0][index] && (tags[0][index] == tag);
  assign hit1     = valid[1][index] && (tags[1][index] == tag);
  assign hit      = hit0 || hit1;
  assign hit_way  = hit1;
  assign hit_word = hit1 ? words[1][index][word_sel] : words[0][index][word_sel];

  // Fill an empty way first (way0 before way1); otherwise evict the LRU way.
  assign victim = !valid[0][index] ? 1'b0 :
                  !valid[1][index] ? 1'b1 : lru[index];

  assign sram_wdata = wdata;

  always_comb begin
    state_next    = state;
    ready         = 1'b0;
    rdata         = '0;
    sram_read_en  = 1'b0;
    sram_write_en = 1'b0;
    sram_address  = {address[31:3], 3'b000};
    case (state)
      IDLE: begin
        if (MEM_W_EN) begin
          state_next = WRITE;
        end else if (MEM_R_EN) begin
          if (hit) begin
            ready = 1'b1;
            rdata = hit_word;
          end else begin
            state_next = FETCH0;
          end
        end else begin
          ready = 1'b1;
        end
      end
      FETCH0: begin
        sram_read_en = 1'b1;
        if (sram_ready) state_next = FETCH1;
      end
      FETCH1: begin
        sram_read_en = 1'b1;
        sram_address = {address[31:3], 3'b100};
        if (sram_ready) state_next = IDLE;
      end
      WRITE: begin
        sram_write_en = 1'b1;
        sram_address  = {address[31:2], 2'b00};
        if (sram_ready) begin
          ready      = 1'b1;
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Control state: FSM, valid, tag and LRU bits.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      valid[0] <= '0;
      valid[1] <= '0;
      lru      <= '0;
    end else begin
      state <= state_next;
      if (state == IDLE && !MEM_W_EN && MEM_R_EN && hit)
        lru[index] <= ~hit_way;
      if (state == FETCH1 && sram_ready) begin
        valid[victim][index] <= 1'b1;
        tags[victim][index]  <= tag;
        lru[index]           <= ~victim;
      end
      if (state == WRITE && sram_ready && hit)
        lru[index] <= ~hit_way;
    end
  end

  // Line data and fill buffer carry no reset; they only matter behind valid.
  always_ff @(posedge clk) begin
    if (state == FETCH0 && sram_ready)
      fill_word0 <= sram_rdata;
    if (!rst && state == FETCH1 && sram_ready) begin
      words[victim][index][0] <= fill_word0;
      words[victim][index][1] <= sram_rdata;
    end else if (!rst && state == WRITE && sram_ready && hit) begin
      words[hit_way][index][word_sel] <= wdata;
    end
  end

endmodule

// File: tb/tb_cache_controller.sv
module tb_cache_controller;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] address, wdata, rdata;
  logic        MEM_R_EN, MEM_W_EN, ready;
  logic [31:0] sram_address, sram_wdata, sram_rdata;
  logic        sram_write_en, sram_read_en, sram_ready;

  cache_controller #(.SETS_LOG2(6), .ADDR_W(19)) dut (
    .clk(clk), .rst(rst), .address(address), .wdata(wdata),
    .MEM_R_EN(MEM_R_EN), .MEM_W_EN(MEM_W_EN), .rdata(rdata), .ready(ready),
    .sram_address(sram_address), .sram_wdata(sram_wdata),
    .sram_write_en(sram_write_en), .sram_read_en(sram_read_en),
    .sram_rdata(sram_rdata), .sram_ready(sram_ready)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%08h expected=0x%08h", name, act, exp);
    end
  endtask

  // Backing store: word address -> data; untouched words read a fixed pattern.
  logic [31:0] mem [logic [31:0]];

  function automatic logic [31:0] mem_rd(input logic [31:0] a);
    logic [31:0] w;
    w = {a[31:2], 2'b00};
    if (mem.exists(w)) return mem[w];
    return w ^ 32'hA5C3_0F96;
  endfunction

  // Cache model: per set a recency list of up to two tags (mru, then older).
  int          m_cnt [64];
  logic [9:0]  m_mru [64];
  logic [9:0]  m_old [64];

  function automatic void model_clear();
    for (int i = 0; i < 64; i++) m_cnt[i] = 0;
  endfunction

  function automatic bit model_access(input logic [31:0] a, input bit is_write);
    int         s;
    logic [9:0] t;
    s = int'(a[8:3]);
    t = a[18:9];
    if (m_cnt[s] >= 1 && m_mru[s] == t) return 1'b1;
    if (m_cnt[s] == 2 && m_old[s] == t) begin
      m_old[s] = m_mru[s];
      m_mru[s] = t;
      return 1'b1;
    end
    if (!is_write) begin
      if (m_cnt[s] >= 1) m_old[s] = m_mru[s];
      m_mru[s] = t;
      if (m_cnt[s] < 2) m_cnt[s]++;
    end
    return 1'b0;
  endfunction

  // SRAM responder: completes a request after sram_lat waiting cycles,
  // or every cycle when fast is set (sram_ready held high).
  bit          fast = 1'b0;
  int          sram_lat = 1;
  int          rsp_cnt = 0;
  int          n_rd = 0;
  int          n_wr = 0;
  logic [31:0] txn_log [$];

  always @(negedge clk) begin
    if (rst) begin
      sram_ready = fast;
      rsp_cnt = 0;
    end else if (sram_read_en || sram_write_en) begin
      sram_ready = fast || (rsp_cnt >= sram_lat);
      if (sram_ready) begin
        txn_log.push_back(sram_address);
        if (sram_write_en) begin
          mem[{sram_address[31:2], 2'b00}] = sram_wdata;
          n_wr++;
        end else begin
          n_rd++;
        end
        rsp_cnt = 0;
      end else begin
        rsp_cnt++;
      end
    end else begin
      sram_ready = fast;
      rsp_cnt = 0;
    end
    sram_rdata = mem_rd(sram_address);
  end

  // Per-cycle compare against the backing store and request rules.
  always @(negedge clk) begin
    #1;
    if (!rst) begin
      chk("req_exclusive", {31'b0, sram_read_en & sram_write_en}, 32'd0);
      if (MEM_R_EN && !MEM_W_EN && ready)
        chk($sformatf("rdata@%08h", address), rdata, mem_rd(address));
      if (sram_read_en)
        chk("rd_addr", sram_address & 32'hFFFF_FFFB, {address[31:3], 3'b000});
      if (sram_write_en) begin
        chk("wr_addr", sram_address, {address[31:2], 2'b00});
        chk("wr_data", sram_wdata, wdata);
      end
      if (!MEM_R_EN && !MEM_W_EN) begin
        chk("idle_ready", {31'b0, ready}, 32'd1);
        chk("idle_noreq", {30'b0, sram_read_en, sram_write_en}, 32'd0);
      end
    end
  end

  task automatic wait_ready(output int stalls);
    stalls = 0;
    @(negedge clk); #2;
    while (ready !== 1'b1 && stalls < 100) begin
      stalls++;
      @(negedge clk); #2;
    end
  endtask

  task automatic clear_txn(input int lat);
    sram_lat = lat;
    n_rd = 0;
    n_wr = 0;
    txn_log.delete();
  endtask

  task automatic do_load(input logic [31:0] a, input bit exp_hit,
                         input logic [31:0] exp_data, input int lat);
    bit          mh;
    int          st;
    logic [31:0] base;
    base = {a[31:3], 3'b000};
    mh = model_access(a, 1'b0);
    chk($sformatf("model_hit@%08h", a), {31'b0, mh}, {31'b0, exp_hit});
    clear_txn(lat);
    @(posedge clk); #1;
    address = a; wdata = $urandom; MEM_R_EN = 1'b1;
    wait_ready(st);
    chk($sformatf("ld_rdata@%08h", a), rdata, exp_data);
    chk($sformatf("ld_stall@%08h", a), st, mh ? 0 : 2 * lat + 3);
    chk($sformatf("ld_reads@%08h", a), n_rd, mh ? 0 : 2);
    chk($sformatf("ld_writes@%08h", a), n_wr, 0);
    if (!mh && txn_log.size() == 2) begin
      chk("ld_fetch0_addr", txn_log[0], base);
      chk("ld_fetch1_addr", txn_log[1], base + 32'd4);
    end
    @(posedge clk); #1;
    MEM_R_EN = 1'b0;
  endtask

  task automatic do_store(input logic [31:0] a, input logic [31:0] d, input bit exp_hit,
                          input int lat, input bit with_read);
    bit mh;
    int st;
    mh = model_access(a, 1'b1);
    chk($sformatf("model_whit@%08h", a), {31'b0, mh}, {31'b0, exp_hit});
    clear_txn(lat);
    @(posedge clk); #1;
    address = a; wdata = d; MEM_W_EN = 1'b1; MEM_R_EN = with_read;
    wait_ready(st);
    chk($sformatf("st_stall@%08h", a), st, lat + 1);
    chk($sformatf("st_writes@%08h", a), n_wr, 1);
    chk($sformatf("st_reads@%08h", a), n_rd, 0);
    if (txn_log.size() == 1)
      chk("st_addr", txn_log[0], {a[31:2], 2'b00});
    @(posedge clk); #1;
    MEM_W_EN = 1'b0; MEM_R_EN = 1'b0;
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_ready"}, {31'b0, ready}, 32'd1);
    chk({tag, "_rd_en"}, {31'b0, sram_read_en}, 32'd0);
    chk({tag, "_wr_en"}, {31'b0, sram_write_en}, 32'd0);
    chk({tag, "_rdata"}, rdata, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout checks=%0d failures=%0d", checks, failures);
    $fatal(1);
  end

  initial begin
    int k;
    rst = 1'b1; address = '0; wdata = '0; MEM_R_EN = 1'b0; MEM_W_EN = 1'b0;
    sram_ready = 1'b0; sram_rdata = '0;
    mem[32'h10] = 32'h11;
    mem[32'h14] = 32'h22;
    model_clear();
    repeat (3) @(posedge clk);
    @(negedge clk); #2;
    check_reset_outputs("reset");
    @(posedge clk); #1;
    rst = 1'b0;

    // Cold miss then hit on the other word of the line.
    do_load(32'h0000_0010, 1'b0, 32'h11, 1);
    do_load(32'h0000_0014, 1'b1, 32'h22, 1);

    // Write-through hit updates the cached word.
    do_store(32'h0000_0014, 32'hDEAD_BEEF, 1'b1, 2, 1'b0);
    do_load(32'h0000_0014, 1'b1, 32'hDEAD_BEEF, 2);
    do_load(32'h0000_0010, 1'b1, 32'h11, 2);

    // Write miss does not allocate.
    do_store(32'h0000_4000, 32'h5, 1'b0, 0, 1'b0);
    do_load(32'h0000_4000, 1'b0, 32'h5, 0);

    // LRU replacement within set 0.
    do_load(32'h0000_0000, 1'b0, mem_rd(32'h0), 1);
    do_load(32'h0000_0200, 1'b0, mem_rd(32'h200), 1);
    do_load(32'h0000_0000, 1'b1, mem_rd(32'h0), 1);
    do_load(32'h0000_0400, 1'b0, mem_rd(32'h400), 1);
    do_load(32'h0000_0004, 1'b1, mem_rd(32'h4), 1);
    do_load(32'h0000_0200, 1'b0, mem_rd(32'h200), 1);
    do_load(32'h0000_4000, 1'b0, 32'h5, 1);

    // Reset in the middle of a fill.
    clear_txn(2);
    @(posedge clk); #1;
    address = 32'h80; MEM_R_EN = 1'b1;
    k = 0;
    while (n_rd < 1 && k < 50) begin
      @(negedge clk); #2;
      k++;
    end
    chk("midfill_first_read", n_rd, 1);
    @(posedge clk); #1;
    rst = 1'b1; MEM_R_EN = 1'b0;
    @(posedge clk);
    @(negedge clk); #2;
    check_reset_outputs("midfill_reset");
    @(posedge clk); #1;
    rst = 1'b0;
    model_clear();
    do_load(32'h0000_0080, 1'b0, mem_rd(32'h80), 2);
    do_load(32'h0000_0010, 1'b0, 32'h11, 2);

    // sram_ready held high: single-cycle requests, read+write treated as write.
    fast = 1'b1;
    do_store(32'h0000_0008, 32'hCAFE_0008, 1'b0, 0, 1'b1);
    do_load(32'h0000_0008, 1'b0, 32'hCAFE_0008, 0);
    do_load(32'h0000_000C, 1'b1, mem_rd(32'hC), 0);
    do_store(32'h0000_000C, 32'h0000_1234, 1'b1, 0, 1'b0);
    do_load(32'h0000_000C, 1'b1, 32'h0000_1234, 0);
    do_store(32'h0000_0008, 32'h0BAD_F00D, 1'b1, 0, 1'b1);
    do_load(32'h0000_0008, 1'b1, 32'h0BAD_F00D, 0);

    repeat (2) @(posedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
